// File: rtl/rx_sample_counter_if.sv
// Handshake bundle between the RX FSM and the oversampling edge/bit counter.
// The master is the RX FSM side. The slave is the counter itself.
interface rx_sample_counter_if #(
   parameter int EDGE_W = 6,
   parameter int BIT_W  = 4
);
   logic              Enable;
   logic              Bit_Rst;
   logic [EDGE_W-1:0] Prescale;
   logic [BIT_W-1:0]  Frame_Len;
   logic [EDGE_W-1:0] edge_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [2:0]        sample_strb;
   logic              bit_tick;
   logic              frame_done;
   logic              cfg_err;

   modport master (
      output Enable, Bit_Rst, Prescale, Frame_Len,
      input  edge_cnt, bit_cnt, sample_strb, bit_tick, frame_done, cfg_err
   );

   modport slave (
      input  Enable, Bit_Rst, Prescale, Frame_Len,
      output edge_cnt, bit_cnt, sample_strb, bit_tick, frame_done, cfg_err
   );
endinterface

// File: rtl/rx_sample_counter.sv
// Oversampling edge/bit counter for the UART receiver. It supports a runtime prescale and
// a runtime frame length, and it decodes mid-bit strobes and bit/frame ticks.
module rx_sample_counter #(
   parameter int EDGE_W = 6,
   parameter int BIT_W  = 4
) (
   input logic                Clk,
   input logic                Rst,
   rx_sample_counter_if.slave bus
);
   logic [EDGE_W-1:0] r_presc_q;
   logic [EDGE_W-1:0] r_edge_cnt;
   logic [BIT_W-1:0]  r_bit_cnt;
   logic              r_cfg_err;

   logic              w_run;
   logic              w_edge_last;
   logic              w_bit_last;
   logic              w_presc_bad;
   logic [EDGE_W-1:0] w_half;
   logic [BIT_W-1:0]  w_last_bit;

   assign w_run       = bus.Enable & ~r_cfg_err;
   assign w_half      = r_presc_q >> 1;
   assign w_edge_last = (r_edge_cnt == r_presc_q - EDGE_W'(1));
   // Frame_Len=0 wraps to all-ones, which gives a frame of 2^BIT_W bits.
   assign w_last_bit  = bus.Frame_Len - BIT_W'(1);
   assign w_bit_last  = (r_bit_cnt == w_last_bit);
   assign w_presc_bad = bus.Prescale[0] | (bus.Prescale < EDGE_W'(4));

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_presc_q  <= EDGE_W'(8);
         r_cfg_err  <= 1'b0;
         r_edge_cnt <= '0;
         r_bit_cnt  <= '0;
      end else if (!bus.Enable) begin
         r_presc_q  <= bus.Prescale;
         r_cfg_err  <= w_presc_bad;
         r_edge_cnt <= '0;
      end else begin
         if (!r_cfg_err) begin
            r_edge_cnt <= w_edge_last ? '0 : r_edge_cnt + EDGE_W'(1);
         end
         // Bit_Rst clears even under cfg_err, and it wins over a bit advance.
         if (bus.Bit_Rst) begin
            r_bit_cnt <= '0;
         end else if (!r_cfg_err && w_edge_last) begin
            r_bit_cnt <= w_bit_last ? '0 : r_bit_cnt + BIT_W'(1);
         end
      end
   end

   assign bus.edge_cnt       = r_edge_cnt;
   assign bus.bit_cnt        = r_bit_cnt;
   assign bus.cfg_err        = r_cfg_err;
   assign bus.sample_strb[0] = w_run & (r_edge_cnt == w_half - EDGE_W'(1));
   assign bus.sample_strb[1] = w_run & (r_edge_cnt == w_half);
   assign bus.sample_strb[2] = w_run & (r_edge_cnt == w_half + EDGE_W'(1));
   assign bus.bit_tick       = w_run & w_edge_last;
   assign bus.frame_done     = w_run & w_edge_last & w_bit_last & ~bus.Bit_Rst;
endmodule
